// File: rtl/uart_word_tx_if.sv
// Word handshake between the write-data path (master) and the UART word
// transmitter (slave).
interface uart_word_tx_if;
   logic [31:0] data_in;
   logic [1:0]  data_len;
   logic        data_valid;
   logic        data_ready;

   modport master (
      output data_in,
      output data_len,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_len,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/uart_word_tx.sv
// Word-oriented 8N1 UART transmitter: sends 1-4 bytes of a latched 32-bit word,
// least-significant byte first, each byte LSB-first.
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic             clk,
   input  logic             reset,
   uart_word_tx_if.slave    bus,
   output logic             tx,
   output logic             busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] baud, baud_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [1:0]    byte_cnt, byte_cnt_nxt;
   logic [31:0]   shreg, shreg_nxt;
   logic          tx_nxt;
   logic          baud_done;

   assign baud_done      = (baud == BAUD_LAST);
   assign bus.data_ready = (state == IDLE);
   assign busy           = (state != IDLE);

   // tx_nxt reflects the level of the state being entered, so the registered
   // line changes on the same edge as the state register.
   always_comb begin
      state_nxt    = state;
      baud_nxt     = baud + CW'(1);
      bit_idx_nxt  = bit_idx;
      byte_cnt_nxt = byte_cnt;
      shreg_nxt    = shreg;
      tx_nxt       = tx;

      unique case (state)
         IDLE: begin
            baud_nxt = '0;
            tx_nxt   = 1'b1;
            if (bus.data_valid) begin
               state_nxt    = START;
               shreg_nxt    = bus.data_in;
               byte_cnt_nxt = bus.data_len;
               bit_idx_nxt  = 3'd0;
               tx_nxt       = 1'b0;
            end
         end

         START: begin
            tx_nxt = 1'b0;
            if (baud_done) begin
               state_nxt   = DATA;
               baud_nxt    = '0;
               bit_idx_nxt = 3'd0;
               tx_nxt      = shreg[0];
            end
         end

         DATA: begin
            tx_nxt = shreg[0];
            if (baud_done) begin
               baud_nxt  = '0;
               shreg_nxt = {1'b0, shreg[31:1]};
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
                  tx_nxt      = shreg[1];
               end
            end
         end

         STOP: begin
            tx_nxt = 1'b1;
            if (baud_done) begin
               baud_nxt = '0;
               if (byte_cnt == 2'd0) begin
                  state_nxt = IDLE;
               end else begin
                  // Next byte already sits in shreg[7:0]; go straight to its start bit.
                  byte_cnt_nxt = byte_cnt - 2'd1;
                  state_nxt    = START;
                  tx_nxt       = 1'b0;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= 3'd0;
         byte_cnt <= 2'd0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud     <= baud_nxt;
         bit_idx  <= bit_idx_nxt;
         byte_cnt <= byte_cnt_nxt;
         tx       <= tx_nxt;
      end
   end

   // Datapath shift register carries no reset; it is always loaded on accept.
   always_ff @(posedge clk) begin
      shreg <= shreg_nxt;
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: stimulus queues expected bytes, a line
// monitor decodes frames from tx and compares against the queue.
module tb_uart_word_tx;

   localparam int CPB = 4;

   logic clk;
   logic reset;
   logic tx;
   logic busy;

   uart_word_tx_if bus ();

   uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .tx    (tx),
      .busy  (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] w, input logic [1:0] len);
      for (int k = 0; k <= int'(len); k++) exp_q.push_back(w[8*k +: 8]);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!bus.data_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   // Returns at the first negedge after the accepting edge (sample 0 of the start bit).
   task automatic send(input logic [31:0] w, input logic [1:0] len, input bit hold);
      @(negedge clk);
      bus.data_in    = w;
      bus.data_len   = len;
      bus.data_valid = 1'b1;
      push_word(w, len);
      wait_idle();
      @(negedge clk);
      if (!hold) bus.data_valid = 1'b0;
   endtask

   // Line-sampling monitor: mid-bit sampling, aborts on a truncated frame.
   initial begin : monitor
      logic       prev;
      logic [7:0] b;
      bit         ok;
      logic [7:0] e;
      prev = 1'b1;
      b    = 8'h00;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && tx === 1'b0 && reset === 1'b0) begin
            ok = 1'b1;
            for (int s = 1; s <= 38; s++) begin
               @(negedge clk);
               if (!busy) begin
                  ok = 1'b0;
                  break;
               end
               if (s >= 6 && s <= 34 && ((s - 6) % 4) == 0) b[(s - 6) / 4] = tx;
            end
            if (ok) begin
               check("stop_bit", {31'd0, tx}, 32'd1);
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("rx_byte", {24'd0, b}, {24'd0, e});
               end
            end
         end
         prev = tx;
      end
   end

   initial begin : stim
      logic [9:0]  f;
      int          cnt;
      logic [31:0] w;
      logic [1:0]  l;

      reset          = 1'b1;
      bus.data_in    = 32'h0;
      bus.data_len   = 2'd0;
      bus.data_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Reset held with valid asserted: nothing may be accepted.
      bus.data_valid = 1'b1;
      bus.data_in    = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         check("rst_tx", {31'd0, tx}, 32'd1);
         check("rst_busy", {31'd0, busy}, 32'd0);
      end
      reset          = 1'b0;
      bus.data_valid = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, bus.data_ready}, 32'd1);
      check("rst_busy_after", {31'd0, busy}, 32'd0);
      check("rst_tx_after", {31'd0, tx}, 32'd1);
      repeat (2) @(negedge clk);

      // Single byte 0xA5 with per-cycle line check.
      f = {1'b1, 8'hA5, 1'b0};
      send(32'h0000_00A5, 2'd0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         check("a5_tx", {31'd0, tx}, {31'd0, f[i / 4]});
         check("a5_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      check("a5_ready_41", {31'd0, bus.data_ready}, 32'd1);
      check("a5_busy_41", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);

      // Full word; inputs scrambled after accept must not matter.
      send(32'h1234_5678, 2'd3, 1'b0);
      bus.data_in  = 32'hFFFF_FFFF;
      bus.data_len = 2'd0;
      cnt = 0;
      while (busy && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      check("word_busy_cycles", cnt, 32'd160);
      repeat (3) @(negedge clk);

      // Back-to-back with valid held.
      send(32'h0000_0041, 2'd0, 1'b1);
      bus.data_in = 32'h0000_0042;
      push_word(32'h0000_0042, 2'd0);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("b2b_first_len", cnt, 32'd40);
      check("b2b_idle_tx", {31'd0, tx}, 32'd1);
      check("b2b_idle_ready", {31'd0, bus.data_ready}, 32'd1);
      @(negedge clk);
      check("b2b_second_start_tx", {31'd0, tx}, 32'd0);
      check("b2b_second_busy", {31'd0, busy}, 32'd1);
      bus.data_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      // Mid-frame reset during bit 3 of byte 1 (samples 56..59 from sample 0).
      send(32'hDEAD_BEEF, 2'd3, 1'b0);
      repeat (57) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_tx", {31'd0, tx}, 32'd1);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_ready", {31'd0, bus.data_ready}, 32'd1);
      check("mrst_queue_left", exp_q.size(), 32'd3);
      exp_q.delete();
      send(32'h0000_0055, 2'd0, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);

      // Random words, lengths and gaps.
      for (int n = 0; n < 200; n++) begin
         w = $urandom;
         l = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         send(w, l, 1'b0);
      end
      wait_idle();
      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
